// File: rtl/median_window_gen.sv
// -----------------------------------------------------------------------------
// median_window_gen
//
// Streaming 3x3 neighbourhood generator for the median filter. Takes a
// raster-order pixel stream, keeps the two previous lines in line buffers, and
// presents one complete 3x3 window per interior centre pixel on s1..s9
// (row-major: s1..s3 top, s4..s6 middle with s5 the centre, s7..s9 bottom).
//
// Parameters:
//   IMG_W  pixels per line (>= 3)
//   IMG_H  lines per frame (>= 3)
//   DW     pixel width (8 when driving the median core)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   pix_valid   pix_data / pix_sof presented this cycle
//   pix_data    pixel value
//   pix_sof     first pixel of frame (qualified by pix_valid)
//   win_valid   s1..s9 hold a new window this cycle
//   s1..s9      registered window taps
//   frame_done  one-cycle pulse with the last window of a frame
//   frame_err   (only with WIN_FRAME_CHECK_EN) sticky framing-error flag
//
// Build option: define WIN_FRAME_CHECK_EN to add the frame_err output and the
// framing checker. Window behaviour is identical in both builds.
// -----------------------------------------------------------------------------
module median_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  input  logic          pix_sof,
  output logic          win_valid,
  output logic [DW-1:0] s1,
  output logic [DW-1:0] s2,
  output logic [DW-1:0] s3,
  output logic [DW-1:0] s4,
  output logic [DW-1:0] s5,
  output logic [DW-1:0] s6,
  output logic [DW-1:0] s7,
  output logic [DW-1:0] s8,
  output logic [DW-1:0] s9,
  output logic          frame_done
`ifdef WIN_FRAME_CHECK_EN
  ,
  output logic          frame_err
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;

  logic            accept_s;
  logic [CW-1:0]   col_cur_s;
  logic [RW-1:0]   row_cur_s;

  // Line buffers: lb1 = previous line, lb2 = the line before it (no reset).
  logic [DW-1:0]   lb1_mem [IMG_W];
  logic [DW-1:0]   lb2_mem [IMG_W];
  logic [DW-1:0]   top_rd_s, mid_rd_s;

  // Column history: entry 0 is column c-2, entry 1 is column c-1. Together
  // with the live column (lb2/lb1 reads and pix_data) this is the 3-column
  // shift window.
  logic [DW-1:0]   top_hist_q [2];
  logic [DW-1:0]   top_hist_d [2];
  logic [DW-1:0]   mid_hist_q [2];
  logic [DW-1:0]   mid_hist_d [2];
  logic [DW-1:0]   bot_hist_q [2];
  logic [DW-1:0]   bot_hist_d [2];

  logic [DW-1:0]   win_q [9];
  logic [DW-1:0]   win_d [9];
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  // Acceptance and the position of the pixel being accepted. A pix_sof pixel
  // is always (0,0), whatever the counters say.
  always_comb begin
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE:   accept_s = pix_valid & pix_sof;
      ST_ACTIVE: accept_s = pix_valid;
      default:   accept_s = 1'b0;
    endcase
    if (pix_sof) begin
      col_cur_s = {CW{1'b0}};
      row_cur_s = {RW{1'b0}};
    end else begin
      col_cur_s = col_q;
      row_cur_s = row_q;
    end
  end

  assign top_rd_s = lb2_mem[col_cur_s];
  assign mid_rd_s = lb1_mem[col_cur_s];

  // Next-state, counters, column history and window formation.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    top_hist_d   = top_hist_q;
    mid_hist_d   = mid_hist_q;
    bot_hist_d   = bot_hist_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept_s) begin
      top_hist_d[0] = top_hist_q[1];
      top_hist_d[1] = top_rd_s;
      mid_hist_d[0] = mid_hist_q[1];
      mid_hist_d[1] = mid_rd_s;
      bot_hist_d[0] = bot_hist_q[1];
      bot_hist_d[1] = pix_data;

      if (col_cur_s == CW'(IMG_W - 1)) begin
        col_d = {CW{1'b0}};
        if (row_cur_s == RW'(IMG_H - 1)) begin
          row_d   = {RW{1'b0}};
          state_d = ST_IDLE;
        end else begin
          row_d   = row_cur_s + RW'(1);
          state_d = ST_ACTIVE;
        end
      end else begin
        col_d   = col_cur_s + CW'(1);
        row_d   = row_cur_s;
        state_d = ST_ACTIVE;
      end

      // Interior only: row/col >= 2 guarantees that every tap was written
      // in the current frame, so stale or unreset data never leaks out.
      if ((row_cur_s >= RW'(2)) && (col_cur_s >= CW'(2))) begin
        win_valid_d  = 1'b1;
        win_d[0]     = top_hist_q[0];
        win_d[1]     = top_hist_q[1];
        win_d[2]     = top_rd_s;
        win_d[3]     = mid_hist_q[0];
        win_d[4]     = mid_hist_q[1];
        win_d[5]     = mid_rd_s;
        win_d[6]     = bot_hist_q[0];
        win_d[7]     = bot_hist_q[1];
        win_d[8]     = pix_data;
        frame_done_d = (row_cur_s == RW'(IMG_H - 1)) &&
                       (col_cur_s == CW'(IMG_W - 1));
      end else begin
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
      end
    end else begin
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // State, counters, history and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        top_hist_q[i] <= {DW{1'b0}};
        mid_hist_q[i] <= {DW{1'b0}};
        bot_hist_q[i] <= {DW{1'b0}};
      end
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      top_hist_q   <= top_hist_d;
      mid_hist_q   <= mid_hist_d;
      bot_hist_q   <= bot_hist_d;
      win_q        <= win_d;
    end
  end

  // Line buffer update: the column's previous line moves up, new pixel enters.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb2_mem[col_cur_s] <= lb1_mem[col_cur_s];
      lb1_mem[col_cur_s] <= pix_data;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign s1 = win_q[0];
  assign s2 = win_q[1];
  assign s3 = win_q[2];
  assign s4 = win_q[3];
  assign s5 = win_q[4];
  assign s6 = win_q[5];
  assign s7 = win_q[6];
  assign s8 = win_q[7];
  assign s9 = win_q[8];

`ifdef WIN_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;
  logic started_q, started_d;

  // Framing checker: sof away from (0,0) while active, or stray pixels in
  // IDLE once any frame has begun. Sticky until reset.
  always_comb begin
    started_d   = started_q | (pix_valid & pix_sof);
    frame_err_d = frame_err_q;
    if (pix_valid && pix_sof && (state_q == ST_ACTIVE) &&
        ((row_q != {RW{1'b0}}) || (col_q != {CW{1'b0}}))) begin
      frame_err_d = 1'b1;
    end else if (pix_valid && !pix_sof && (state_q == ST_IDLE) && started_q) begin
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Framing checker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      started_q   <= started_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_median_window_gen.sv
// -----------------------------------------------------------------------------
// tb_median_window_gen
//
// Scoreboard bench for median_window_gen (IMG_W=5, IMG_H=4, DW=8). The driver
// feeds a frame model (a 2-D image array plus a raster position); each
// accepted pixel that completes an interior window pushes the expected
// window, frame_done flag and arrival cycle into a queue. An independent
// monitor pops and compares on every win_valid.
// -----------------------------------------------------------------------------
module tb_median_window_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = 8'h00;
  logic          pix_sof = 1'b0;
  logic          win_valid, frame_done;
  logic [DW-1:0] s1, s2, s3, s4, s5, s6, s7, s8, s9;
`ifdef WIN_FRAME_CHECK_EN
  logic          frame_err;
`endif

  median_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
    .win_valid(win_valid),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
    .s6(s6), .s7(s7), .s8(s8), .s9(s9),
    .frame_done(frame_done)
`ifdef WIN_FRAME_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9*DW-1:0] w;
    logic            fd;
    int              stamp;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference frame model
  logic [DW-1:0] m_img [H][W];
  bit m_active  = 1'b0;
  int m_r = 0;
  int m_c = 0;
  bit m_started = 1'b0;
  bit m_err     = 1'b0;

  // Monitor statistics
  bit              mon_en = 1'b0;
  int              win_cnt = 0;
  int              fd_cnt = 0;
  logic [9*DW-1:0] first_w;
  exp_t            mon_e;

  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit sof);
    bit acc;
    exp_t e;
    if (v && sof && m_active && (m_r != 0 || m_c != 0)) m_err = 1'b1;
    if (v && !sof && !m_active && m_started) m_err = 1'b1;
    if (v && sof) m_started = 1'b1;
    acc = v && (m_active || sof);
    if (acc) begin
      if (sof) begin
        m_r = 0;
        m_c = 0;
        m_active = 1'b1;
      end
      m_img[m_r][m_c] = d;
      if (m_r >= 2 && m_c >= 2) begin
        e.w = {m_img[m_r-2][m_c-2], m_img[m_r-2][m_c-1], m_img[m_r-2][m_c],
               m_img[m_r-1][m_c-2], m_img[m_r-1][m_c-1], m_img[m_r-1][m_c],
               m_img[m_r][m_c-2],   m_img[m_r][m_c-1],   m_img[m_r][m_c]};
        e.fd = (m_r == H - 1) && (m_c == W - 1);
        e.stamp = cyc + 1;
        exp_q.push_back(e);
      end
      m_c = m_c + 1;
      if (m_c == W) begin
        m_c = 0;
        m_r = m_r + 1;
        if (m_r == H) begin
          m_r = 0;
          m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit sof);
    @(negedge clk);
    pix_valid = v;
    pix_data  = d;
    pix_sof   = sof;
    model_step(v, d, sof);
  endtask

  task automatic send_frame(input int base, input int gap_max, input bit rnd, input int npix);
    logic [DW-1:0] d;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c < npix) begin
          repeat ($urandom_range(0, gap_max))
            drive(1'b0, DW'($urandom), 1'($urandom_range(0, 1)));
          d = rnd ? DW'($urandom) : DW'(base + r * 16 + c);
          drive(1'b1, d, (r == 0 && c == 0));
        end
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Idle a few cycles, then confirm the scoreboard drained and counts match.
  task automatic drain(input string name, input int want_win, input int want_fd);
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    check_val({name, "_pending"}, exp_q.size(), 0);
    check_val({name, "_windows"}, win_cnt, want_win);
    check_val({name, "_frame_done"}, fd_cnt, want_fd);
    exp_q.delete();
    win_cnt = 0;
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_val("rst_win_valid", int'(win_valid), 0);
    check_val("rst_frame_done", int'(frame_done), 0);
    checks++;
    if ({s1, s2, s3, s4, s5, s6, s7, s8, s9} !== {9*DW{1'b0}}) begin
      errors++;
      $display("FAIL rst_taps got=%h expected=0", {s1, s2, s3, s4, s5, s6, s7, s8, s9});
    end
`ifdef WIN_FRAME_CHECK_EN
    check_val("rst_frame_err", int'(frame_err), 0);
`endif
    check_val("rst_pending", exp_q.size(), 0);
    exp_q.delete();
    m_active = 1'b0;
    m_r = 0;
    m_c = 0;
    m_started = 1'b0;
    m_err = 1'b0;
    win_cnt = 0;
    fd_cnt = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic check_err(input string name);
`ifdef WIN_FRAME_CHECK_EN
    check_val(name, int'(frame_err), int'(m_err));
`endif
  endtask

  // Monitor: every presented window must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (win_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window got=%h", {s1, s2, s3, s4, s5, s6, s7, s8, s9});
        end else begin
          mon_e = exp_q.pop_front();
          if ({s1, s2, s3, s4, s5, s6, s7, s8, s9} !== mon_e.w ||
              frame_done !== mon_e.fd || cyc != mon_e.stamp) begin
            errors++;
            $display("FAIL window got=%h fd=%b cyc=%0d expected=%h fd=%b cyc=%0d",
                     {s1, s2, s3, s4, s5, s6, s7, s8, s9}, frame_done, cyc,
                     mon_e.w, mon_e.fd, mon_e.stamp);
          end
          if (win_cnt == 0) first_w = {s1, s2, s3, s4, s5, s6, s7, s8, s9};
          win_cnt++;
          if (frame_done === 1'b1) fd_cnt++;
        end
      end else if (frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_without_window got=%b expected=0", frame_done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    do_reset();

    // Basic frame, continuous valid
    send_frame(0, 0, 1'b0, W * H);
    drain("basic", 6, 1);
    check_val("basic_first_s1", int'(first_w[9*DW-1 -: DW]), 'h00);
    check_val("basic_first_s5", int'(first_w[5*DW-1 -: DW]), 'h11);
    check_val("basic_first_s9", int'(first_w[DW-1:0]), 'h22);
    check_err("basic_frame_err");

    // Same frame with random valid gaps
    send_frame(0, 3, 1'b0, W * H);
    drain("gaps", 6, 1);

    // Pre-sof traffic right after reset
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, DW'($urandom), 1'b0);
    send_frame(0, 0, 1'b0, W * H);
    drain("presof", 6, 1);
    check_err("presof_frame_err");

    // Mid-frame sof at (2,1), then a full 0x80-based frame
    send_frame(0, 0, 1'b0, 2 * W + 1);
    send_frame('h80, 0, 1'b0, W * H);
    drain("midsof", 6, 1);
    check_val("midsof_first_s1", int'(first_w[9*DW-1 -: DW]), 'h80);
    check_val("midsof_first_s9", int'(first_w[DW-1:0]), 'hA2);
    check_err("midsof_frame_err");

    // Reset pulse at (3,0), stray pixels, then a clean frame
    send_frame(0, 0, 1'b0, 3 * W);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, DW'($urandom), 1'b0);
    send_frame(0, 0, 1'b0, W * H);
    drain("rstpulse", 6, 1);
    check_err("rstpulse_frame_err");

    // sof on the final pixel slot: no final window, no frame_done
    send_frame(0, 0, 1'b0, W * H - 1);
    send_frame('h40, 1, 1'b0, W * H);
    drain("sof_at_last", 11, 1);

    // Random pixel values with gaps
    send_frame(0, 2, 1'b1, W * H);
    drain("random", 6, 1);
    check_err("random_frame_err");

    // Stray pixel in IDLE, then a clean frame
    drive(1'b1, 8'h55, 1'b0);
    send_frame(0, 1, 1'b0, W * H);
    drain("stray", 6, 1);
    check_err("stray_frame_err");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
